// File: rtl/ps2_pkg.sv
// Purpose : shared constants, event type and FSM states for the PS/2 receiver slice.
// Contents: PS2_EXT/PS2_BRK prefix codes, frame length, ps2_evt_t, ps2_state_t,
//           odd-parity helper used by the frame check.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  // One decoded key event: prefix flags folded in with the scan code.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK
  } ps2_state_t;

  // Data byte plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_event_fifo_if.sv
// Purpose : key-event pop port (valid/ready handshake plus head event fields).
// Ports   : master = event source (drives valid/code/ext/brk, reads ready);
//           slave  = consumer (reads event, drives ready).
interface ps2_rx_event_fifo_if;

  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_brk,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_brk,
    output evt_ready
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Purpose : generic synchronous first-word-fall-through FIFO (WIDTH x DEPTH, DEPTH power of two).
// Latency : a push is visible at dout/!empty on the cycle after it is written.
// Backpr. : push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports   : clk50/reset, push/din/full, pop/dout/empty, count (entries held).
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk50,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk50) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_event_fifo.sv
// Purpose : PS/2 keyboard receiver - sync+filter pins, deserialise 11-bit frames, check
//           start/parity/stop, fold E0/F0 prefixes into key events, buffer in an FWFT FIFO.
// Latency : event visible on evt (valid) 2 clk50 cycles after the frame-check cycle.
// Backpr. : evt_ready low holds the head stable; a push into a full FIFO without a pop is
//           dropped with a 1-cycle overflow pulse.
// Ports   : clk50, reset (sync, active-high), ps2_clk/ps2_dat raw pins, evt (master pop
//           port), evt_count, err_parity / err_frame / overflow pulses.
module ps2_rx_event_fifo
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DIV = 2,
  parameter int FILT_LEN   = 8,
  parameter int TIMEOUT_TK = 50000,
  parameter int DEPTH      = 8
) (
  input  logic                   clk50,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_dat,
  ps2_rx_event_fifo_if.master    evt,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   err_parity,
  output logic                   err_frame,
  output logic                   overflow
);

  localparam int             DW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam int             TW       = $clog2(TIMEOUT_TK + 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_TK - 1);
  localparam logic [3:0]     LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  // ---------------------------------------------------------------- sample tick
  logic [DW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge clk50) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // ------------------------------------------------- synchroniser and filter
  logic [1:0]          clk_sync;
  logic [1:0]          dat_sync;
  logic [FILT_LEN-1:0] clk_sh;
  logic [FILT_LEN-1:0] dat_sh;
  logic                clk_f;
  logic                dat_f;
  logic                clk_f_d;
  logic                fall;

  always_ff @(posedge clk50) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_sh   <= '1;
      dat_sh   <= '1;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_d  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      if (tick) begin
        clk_sh  <= {clk_sh[FILT_LEN-2:0], clk_sync[1]};
        dat_sh  <= {dat_sh[FILT_LEN-2:0], dat_sync[1]};
        clk_f_d <= clk_f;
      end
      // Filtered level moves only once the whole window agrees; otherwise it holds.
      if (&clk_sh)       clk_f <= 1'b1;
      else if (~|clk_sh) clk_f <= 1'b0;
      if (&dat_sh)       dat_f <= 1'b1;
      else if (~|dat_sh) dat_f <= 1'b0;
    end
  end

  // clk_f_d only advances on ticks, so a fall is seen exactly once, on a tick.
  assign fall = tick & clk_f_d & ~clk_f;

  // ------------------------------------------- frame FSM, timeout and decoder
  ps2_state_t                state;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic [3:0]                bit_cnt;
  logic [TW-1:0]             to_cnt;
  logic                      ext_pend;
  logic                      brk_pend;
  logic                      push_req;
  ps2_evt_t                  push_dat;

  always_ff @(posedge clk50) begin
    if (reset) begin
      state      <= IDLE;
      frame      <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      push_req   <= 1'b0;
      push_dat   <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      push_req   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall) begin
            // Shift right: after all bits, frame[0] is the start bit.
            frame   <= {dat_f, frame[PS2_FRAME_BITS-1:1]};
            bit_cnt <= 4'd1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (fall) begin
            frame  <= {dat_f, frame[PS2_FRAME_BITS-1:1]};
            to_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (tick) begin
            if (to_cnt == TO_LAST) begin
              err_frame <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
              state     <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          state <= IDLE;
          if (frame[0] || !frame[PS2_FRAME_BITS-1]) begin
            err_frame <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end else if (!odd_parity_ok(frame[9:1])) begin
            err_parity <= 1'b1;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
          end else if (frame[8:1] == PS2_EXT) begin
            ext_pend <= 1'b1;
          end else if (frame[8:1] == PS2_BRK) begin
            brk_pend <= 1'b1;
          end else begin
            push_req      <= 1'b1;
            push_dat.ext  <= ext_pend;
            push_dat.brk  <= brk_pend;
            push_dat.code <= frame[8:1];
            ext_pend      <= 1'b0;
            brk_pend      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- event FIFO
  logic     fifo_full;
  logic     fifo_empty;
  logic     evt_pop;
  ps2_evt_t head;

  assign evt_pop = ~fifo_empty & evt.evt_ready;

  ps2_evt_fifo #(
    .WIDTH($bits(ps2_evt_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk50 (clk50),
    .reset (reset),
    .push  (push_req),
    .din   (push_dat),
    .full  (fifo_full),
    .pop   (evt_pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (evt_count)
  );

  always_ff @(posedge clk50) begin
    if (reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_req & fifo_full & ~evt_pop;
    end
  end

  // Head fields are forced to zero while empty so nothing stale leaks out.
  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_code  = fifo_empty ? 8'h00 : head.code;
  assign evt.evt_ext   = ~fifo_empty & head.ext;
  assign evt.evt_brk   = ~fifo_empty & head.brk;

endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
module tb_ps2_rx_event_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO_TK = 200;

  logic       clk50 = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [3:0] evt_count;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;

  ps2_rx_event_fifo_if evt_if ();

  ps2_rx_event_fifo #(
    .SAMPLE_DIV(2),
    .FILT_LEN  (8),
    .TIMEOUT_TK(TO_TK),
    .DEPTH     (DEPTH)
  ) dut (
    .clk50     (clk50),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .evt       (evt_if),
    .evt_count (evt_count),
    .err_parity(err_parity),
    .err_frame (err_frame),
    .overflow  (overflow)
  );

  always #5 clk50 = ~clk50;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovf = 0;
  ps2_evt_t exp_q[$];
  ps2_evt_t mon_exp;
  ps2_evt_t mon_got;

  // Scoreboard: every accepted pop is compared against the oldest expected event.
  always @(negedge clk50) begin
    if (err_parity) n_par++;
    if (err_frame)  n_frm++;
    if (overflow)   n_ovf++;
    if (evt_if.evt_valid && evt_if.evt_ready) begin
      mon_got = '{ext: evt_if.evt_ext, brk: evt_if.evt_brk, code: evt_if.evt_code};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL evt_unexpected: got ext=%0b brk=%0b code=%02h, required no event",
                 mon_got.ext, mon_got.brk, mon_got.code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          tests_failed++;
          $display("FAIL evt_data: got ext=%0b brk=%0b code=%02h, required ext=%0b brk=%0b code=%02h",
                   mon_got.ext, mon_got.brk, mon_got.code, mon_exp.ext, mon_exp.brk, mon_exp.code);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk50);
      #1;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(6);
        ps2_clk = 1'b1;
        wait_cyc(9);
      end else begin
        wait_cyc(20);
      end
      ps2_clk = 1'b0;
      wait_cyc(40);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
  endtask

  task automatic send_byte(input logic [7:0] code, input logic bad_par,
                           input logic bad_stop, input int glitch_bit);
    logic [10:0] b;
    b = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    send_bits(b, 11, glitch_bit);
    ps2_dat = 1'b1;
    wait_cyc(60);
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; evt_if.evt_ready = 1'b0;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    tests_run++;
    if (evt_if.evt_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b, required 0", evt_if.evt_valid); end
    tests_run++;
    if (evt_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d, required 0", evt_count); end
    tests_run++;
    if ({err_parity, err_frame, overflow} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_pulses: got %03b, required 000", {err_parity, err_frame, overflow});
    end
    tests_run++;
    if ({evt_if.evt_code, evt_if.evt_ext, evt_if.evt_brk} !== 10'd0) begin
      tests_failed++; $display("FAIL reset_evt_fields: got %03h, required 000", {evt_if.evt_code, evt_if.evt_ext, evt_if.evt_brk});
    end
  endtask

  task automatic test_single();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    evt_if.evt_ready = 1'b1;
    exp_q.push_back('{ext: 1'b0, brk: 1'b0, code: 8'h1C});
    send_byte(8'h1C, 1'b0, 1'b0, -1);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL single_event: %0d events outstanding, required 0", exp_q.size()); end
    tests_run++;
    if ((n_par - p0) + (n_frm - f0) != 0) begin
      tests_failed++; $display("FAIL single_no_err: got %0d error pulses, required 0", (n_par - p0) + (n_frm - f0));
    end
  endtask

  task automatic test_prefix();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    exp_q.push_back('{ext: 1'b0, brk: 1'b1, code: 8'h1C});
    exp_q.push_back('{ext: 1'b1, brk: 1'b1, code: 8'h75});
    send_byte(8'hF0, 1'b0, 1'b0, -1);
    send_byte(8'h1C, 1'b0, 1'b0, -1);
    send_byte(8'hE0, 1'b0, 1'b0, -1);
    send_byte(8'hF0, 1'b0, 1'b0, -1);
    send_byte(8'h75, 1'b0, 1'b0, -1);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL prefix_events: %0d events outstanding, required 0", exp_q.size()); end
    tests_run++;
    if ((n_par - p0) + (n_frm - f0) != 0) begin
      tests_failed++; $display("FAIL prefix_no_err: got %0d error pulses, required 0", (n_par - p0) + (n_frm - f0));
    end
  endtask

  task automatic test_parity_err();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_byte(8'h1C, 1'b1, 1'b0, -1);
    tests_run++;
    if (n_par - p0 != 1) begin tests_failed++; $display("FAIL parity_pulse: got %0d, required 1", n_par - p0); end
    tests_run++;
    if (n_frm - f0 != 0) begin tests_failed++; $display("FAIL parity_no_frame_err: got %0d, required 0", n_frm - f0); end
  endtask

  task automatic test_frame_err();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_byte(8'h1C, 1'b0, 1'b1, -1);
    tests_run++;
    if (n_frm - f0 != 1) begin tests_failed++; $display("FAIL stop_frame_pulse: got %0d, required 1", n_frm - f0); end
    tests_run++;
    if (n_par - p0 != 0) begin tests_failed++; $display("FAIL stop_no_parity_err: got %0d, required 0", n_par - p0); end
  endtask

  task automatic test_timeout();
    int f0;
    logic [10:0] b;
    f0 = n_frm;
    b = {1'b1, ~^8'h29, 8'h29, 1'b0};
    send_bits(b, 5, -1);
    ps2_dat = 1'b1;
    wait_cyc(3 * TO_TK);
    tests_run++;
    if (n_frm - f0 != 1) begin tests_failed++; $display("FAIL timeout_pulse: got %0d, required 1", n_frm - f0); end
    f0 = n_frm;
    exp_q.push_back('{ext: 1'b0, brk: 1'b0, code: 8'h29});
    send_byte(8'h29, 1'b0, 1'b0, -1);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL timeout_recover: %0d events outstanding, required 0", exp_q.size()); end
    tests_run++;
    if (n_frm - f0 != 0) begin tests_failed++; $display("FAIL timeout_recover_err: got %0d, required 0", n_frm - f0); end
  endtask

  task automatic test_overflow();
    int o0;
    o0 = n_ovf;
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back('{ext: 1'b0, brk: 1'b0, code: 8'h10 + 8'(i)});
      send_byte(8'h10 + 8'(i), 1'b0, 1'b0, -1);
    end
    tests_run++;
    if (evt_count !== 4'(DEPTH)) begin tests_failed++; $display("FAIL ovf_count: got %0d, required %0d", evt_count, DEPTH); end
    tests_run++;
    if (n_ovf - o0 != 1) begin tests_failed++; $display("FAIL ovf_pulse: got %0d, required 1", n_ovf - o0); end
    tests_run++;
    if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 8'h10) begin
      tests_failed++; $display("FAIL ovf_head_hold: got valid=%0b code=%02h, required valid=1 code=10", evt_if.evt_valid, evt_if.evt_code);
    end
    evt_if.evt_ready = 1'b1;
    wait_cyc(DEPTH + 5);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ovf_drain: %0d events outstanding, required 0", exp_q.size()); end
    tests_run++;
    if (evt_count !== 4'd0) begin tests_failed++; $display("FAIL ovf_drain_count: got %0d, required 0", evt_count); end
  endtask

  task automatic test_glitch();
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    exp_q.push_back('{ext: 1'b0, brk: 1'b0, code: 8'h5A});
    send_byte(8'h5A, 1'b0, 1'b0, 3);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL glitch_event: %0d events outstanding, required 0", exp_q.size()); end
    tests_run++;
    if ((n_par - p0) + (n_frm - f0) != 0) begin
      tests_failed++; $display("FAIL glitch_no_err: got %0d error pulses, required 0", (n_par - p0) + (n_frm - f0));
    end
  endtask

  task automatic test_reset_midframe();
    int p0, f0, o0;
    logic [10:0] b;
    evt_if.evt_ready = 1'b0;
    send_byte(8'h44, 1'b0, 1'b0, -1);
    p0 = n_par; f0 = n_frm; o0 = n_ovf;
    b = {1'b1, ~^8'h66, 8'h66, 1'b0};
    send_bits(b, 5, -1);
    ps2_dat = 1'b1;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(3 * TO_TK);
    tests_run++;
    if (evt_count !== 4'd0 || evt_if.evt_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_fifo: got count=%0d valid=%0b, required 0/0", evt_count, evt_if.evt_valid);
    end
    tests_run++;
    if ((n_par - p0) + (n_frm - f0) + (n_ovf - o0) != 0) begin
      tests_failed++; $display("FAIL rst_mid_pulses: got %0d, required 0", (n_par - p0) + (n_frm - f0) + (n_ovf - o0));
    end
    evt_if.evt_ready = 1'b1;
    exp_q.push_back('{ext: 1'b0, brk: 1'b0, code: 8'h33});
    send_byte(8'h33, 1'b0, 1'b0, -1);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rst_mid_next: %0d events outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
